alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits (8..64, power of two).
REQ-002 Parameter SHW, default $clog2(WIDTH), width of the shift-amount field taken from src_b.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  unit accepts a request this cycle.
REQ-007 alu_op  input  2  class: 10 load/store, 01 branch, 00 R-type.
REQ-008 opcode  input  4  R-type function select.
REQ-009 src_a, src_b  input  WIDTH each  operands.
REQ-010 out_valid  output  1  result/zero valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero  output  1  result == 0, registered with result.

Function
REQ-014 Decode:
- alu_op 10 -> ADD.
- alu_op 01 -> SUB.
- alu_op 00: opcode 0010 ADD, 0011 SUB, 0100 NOT, 0101 SHL, 0110 SHR, 0111 AND, 1000 OR, 1001 SLT.
- All other combinations (including alu_op 11) -> ADD.
REQ-015 ADD/SUB are modulo 2^WIDTH with no carry/overflow output; NOT = ~src_a; SLT = 1 when src_a < src_b as signed two's complement, else 0, zero-extended to WIDTH.
REQ-016 SHL/SHR are logical shifts of src_a by k = src_b[SHW-1:0]; upper src_b bits are ignored; vacated bits are filled with 0.
REQ-017 FSM states: IDLE, SHIFT, MUL, HOLD; a request is accepted on an edge where in_valid && in_ready.
REQ-018 in_ready = (state==IDLE) || (state==HOLD && out_ready), combinational.
REQ-019 Single-cycle ops (all except SHL/SHR with k>0, and MUL): result is registered on the accept edge; FSM -> HOLD; out_valid is 1 in the following cycle.
REQ-020 SHL/SHR with k>0: accept edge loads src_a and count=k, FSM -> SHIFT; each SHIFT edge shifts one bit and decrements count; the edge on which count reaches 0 -> HOLD; out_valid is 1 after the k-th edge following acceptance.
REQ-021 SHL/SHR with k=0 behave as single-cycle and return src_a.
REQ-022 HOLD: result, zero and out_valid stay stable until out_ready=1; on that edge, FSM -> IDLE, or directly to the next op's state if a new request is accepted on the same edge (back-to-back, no bubble).
REQ-023 In SHIFT and MUL, in_ready=0 and out_valid=0; in_valid is ignored and the operand inputs may change freely.
REQ-024 out_ready is ignored while out_valid=0.

Reset
REQ-025 When rst=1 at a rising edge: FSM -> IDLE, out_valid=0, result=0, zero=1, internal count=0; any in-flight SHIFT/MUL operation or held result is discarded.
REQ-026 rst overrides a simultaneous accept: a request presented on the reset edge is not executed.
REQ-027 in_ready is 0 during the reset cycle and is 1 in the first cycle after reset.

Configuration
REQ-028 Macro ALU_EXEC_MUL_EN.
- Defined: alu_op 00 / opcode 1010 = MUL, giving the low WIDTH bits of src_a*src_b (unsigned) via iterative shift-add. The accept edge enters MUL; HOLD is reached after exactly WIDTH further edges.
- Undefined: opcode 1010 decodes as ADD, and the MUL state and multiplier logic do not exist.

Verification (WIDTH=16)
REQ-029 Reset, then alu_op=00 opcode=0011, a=0x0005, b=0x0007, out_ready=1 -> one cycle later out_valid=1, result=0xFFFE, zero=0.
REQ-030 alu_op=01, a=b=0x1234 -> result=0x0000, zero=1; then opcode=1001 with a=0x8000, b=0x0001 -> result=0x0001.
REQ-031 SHL, a=0x0001, b=0xFFF3 (k=3) -> in_ready=0 for 3 cycles, out_valid after the 3rd edge, result=0x0008; SHR with k=0 and a=0xABCD -> result=0xABCD after 1 cycle.
REQ-032 out_ready=0 for 5 cycles while holding 0x00FF -> result stable, in_ready=0; raise out_ready together with a new ADD 1+1 -> next cycle result=0x0002.
REQ-033 Assert rst during a SHIFT with k=10 at cycle 4 -> next cycle out_valid=0, result=0, in_ready=1; no stale result appears afterwards.
REQ-034 With ALU_EXEC_MUL_EN: MUL a=0x0123, b=0x0010 -> out_valid after 16 edges, result=0x1230. Without it: the same stimulus -> result=0x0133 after 1 cycle.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU with single-cycle ops, bit-serial shifts
// and an optional iterative shift-add multiplier.
// Optional feature macro: ALU_EXEC_MUL_EN (enables MUL on alu_op 00 / opcode 1010).
module alu_exec_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    // Counter wide enough to hold WIDTH itself (multiplier iteration count).
    localparam int CW = SHW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
`ifdef ALU_EXEC_MUL_EN
        ,
        S_MUL   = 2'd3
`endif
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_NOT,
        OP_SHL,
        OP_SHR,
        OP_AND,
        OP_OR,
        OP_SLT
`ifdef ALU_EXEC_MUL_EN
        ,
        OP_MUL
`endif
    } op_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] work_q, work_d;     // shift operand, or multiplier accumulator
    logic [CW-1:0]    count_q, count_d;
    logic             dir_q, dir_d;       // 1 = shift right
`ifdef ALU_EXEC_MUL_EN
    localparam logic [CW-1:0] MUL_CNT = CW'(WIDTH);
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_sum;
`endif

    op_e              op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] shifted;
    logic             accept;

    assign shamt     = src_b[SHW-1:0];
    assign out_valid = (state_q == S_HOLD);
    assign in_ready  = !rst && ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign result    = result_q;
    assign zero      = zero_q;
    assign shifted   = dir_q ? (work_q >> 1) : (work_q << 1);
`ifdef ALU_EXEC_MUL_EN
    assign acc_sum   = mplier_q[0] ? (work_q + mcand_q) : work_q;
`endif

    // Decode the operation class and function select; anything unlisted is ADD.
    always_comb begin
        op = OP_ADD;
        if (alu_op == 2'b01) begin
            op = OP_SUB;
        end else if (alu_op == 2'b00) begin
            case (opcode)
                4'b0011: op = OP_SUB;
                4'b0100: op = OP_NOT;
                4'b0101: op = OP_SHL;
                4'b0110: op = OP_SHR;
                4'b0111: op = OP_AND;
                4'b1000: op = OP_OR;
                4'b1001: op = OP_SLT;
`ifdef ALU_EXEC_MUL_EN
                4'b1010: op = OP_MUL;
`endif
                default: op = OP_ADD;
            endcase
        end
    end

    // Single-cycle result; shifts here only matter for k==0 (returns src_a).
    always_comb begin
        case (op)
            OP_SUB:  alu_res = src_a - src_b;
            OP_NOT:  alu_res = ~src_a;
            OP_SHL:  alu_res = src_a << shamt;
            OP_SHR:  alu_res = src_a >> shamt;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_res = src_a + src_b;
        endcase
    end

    // Next-state and datapath: accept from IDLE/HOLD, iterate in SHIFT/MUL.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        work_d   = work_q;
        count_d  = count_q;
        dir_d    = dir_q;
`ifdef ALU_EXEC_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (accept) begin
                    if ((op == OP_SHL || op == OP_SHR) && (shamt != '0)) begin
                        state_d = S_SHIFT;
                        work_d  = src_a;
                        count_d = {1'b0, shamt};
                        dir_d   = (op == OP_SHR);
`ifdef ALU_EXEC_MUL_EN
                    end else if (op == OP_MUL) begin
                        state_d  = S_MUL;
                        work_d   = '0;
                        mcand_d  = src_a;
                        mplier_d = src_b;
                        count_d  = MUL_CNT;
`endif
                    end else begin
                        state_d  = S_HOLD;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                    end
                end else if (state_q == S_HOLD && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                work_d  = shifted;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d  = S_HOLD;
                    result_d = shifted;
                    zero_d   = (shifted == '0);
                end
            end
`ifdef ALU_EXEC_MUL_EN
            S_MUL: begin
                work_d   = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d  = S_HOLD;
                    result_d = acc_sum;
                    zero_d   = (acc_sum == '0);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any in-flight or held operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            work_q   <= '0;
            count_q  <= '0;
            dir_q    <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            work_q   <= work_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
`ifdef ALU_EXEC_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=16).
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [3:0]  opcode;
    logic [15:0] src_a;
    logic [15:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        zero;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .opcode    (opcode),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait (bounded) for out_valid; latency counts the accept edge.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] fn,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input int exp_lat);
        int lat;
        lat      = 0;
        alu_op   = op;
        opcode   = fn;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        do begin
            step();
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 40);
        $display("[TB] %s a=%h b=%h result=%h zero=%b latency=%0d", tag, a, b, result, zero, lat);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " result"}, result, exp_res);
        chk({tag, " zero"}, zero, (exp_res == 16'h0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 2'b00; opcode = 4'h0; src_a = 16'h0; src_b = 16'h0;

        // Reset state
        step(); step();
        chk("rst in_ready", in_ready, 1'b0);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst result", result, 16'h0);
        chk("rst zero", zero, 1'b1);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", in_ready, 1'b1);

        // Single-cycle ops, back-to-back with out_ready high
        out_ready = 1'b1;
        run_op("SUB 5-7", 2'b00, 4'b0011, 16'h0005, 16'h0007, 16'hFFFE, 1);
        run_op("BR SUB eq", 2'b01, 4'b0000, 16'h1234, 16'h1234, 16'h0000, 1);
        run_op("SLT neg<1", 2'b00, 4'b1001, 16'h8000, 16'h0001, 16'h0001, 1);
        run_op("SLT 1<neg", 2'b00, 4'b1001, 16'h0001, 16'h8000, 16'h0000, 1);
        run_op("NOT", 2'b00, 4'b0100, 16'h00F0, 16'h5555, 16'hFF0F, 1);
        run_op("AND", 2'b00, 4'b0111, 16'hF0F0, 16'h3C3C, 16'h3030, 1);
        run_op("OR", 2'b00, 4'b1000, 16'hF000, 16'h000F, 16'hF00F, 1);
        run_op("LS ADD wrap", 2'b10, 4'b0011, 16'hFFFF, 16'h0002, 16'h0001, 1);
        run_op("op11 ADD", 2'b11, 4'b0011, 16'h0003, 16'h0004, 16'h0007, 1);
        run_op("opc1111 ADD", 2'b00, 4'b1111, 16'h0002, 16'h0003, 16'h0005, 1);
        run_op("SHR k0", 2'b00, 4'b0110, 16'hABCD, 16'h0010, 16'hABCD, 1);
        run_op("SHR k4", 2'b00, 4'b0110, 16'hF000, 16'h0004, 16'h0F00, 5);
        run_op("SHL k15", 2'b00, 4'b0101, 16'h0001, 16'h001F, 16'h8000, 16);

        // SHL k=3 with in_ready watch; inputs toggled during SHIFT must be ignored
        alu_op = 2'b00; opcode = 4'b0101; src_a = 16'h0001; src_b = 16'hFFF3; in_valid = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("SHL busy in_ready", in_ready, 1'b0);
            chk("SHL busy out_valid", out_valid, 1'b0);
            in_valid = 1'b1; alu_op = 2'b10; src_a = 16'h1111; src_b = 16'h2222;
            step();
        end
        in_valid = 1'b0;
        $display("[TB] SHL k3 result=%h out_valid=%b", result, out_valid);
        chk("SHL k3 out_valid", out_valid, 1'b1);
        chk("SHL k3 result", result, 16'h0008);

        // Hold with out_ready low, then release together with a new ADD
        step();
        out_ready = 1'b0;
        run_op("OR hold", 2'b00, 4'b1000, 16'h00F0, 16'h000F, 16'h00FF, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold result", result, 16'h00FF);
            chk("hold in_ready", in_ready, 1'b0);
            chk("hold out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        alu_op = 2'b00; opcode = 4'b0010; src_a = 16'h0001; src_b = 16'h0001; in_valid = 1'b1;
        #1;
        chk("release in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        $display("[TB] ADD after hold result=%h", result);
        chk("b2b ADD result", result, 16'h0002);
        chk("b2b ADD out_valid", out_valid, 1'b1);

        // Reset in the middle of SHL k=10; a request on the reset edge is dropped
        alu_op = 2'b00; opcode = 4'b0101; src_a = 16'h0003; src_b = 16'h000A; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        alu_op = 2'b00; opcode = 4'b0010; src_a = 16'h0005; src_b = 16'h0005; in_valid = 1'b1;
        #1;
        chk("rst-cycle in_ready", in_ready, 1'b0);
        step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        $display("[TB] reset mid-shift result=%h out_valid=%b in_ready=%b", result, out_valid, in_ready);
        chk("mid rst out_valid", out_valid, 1'b0);
        chk("mid rst result", result, 16'h0);
        chk("mid rst zero", zero, 1'b1);
        chk("mid rst in_ready", in_ready, 1'b1);
        hits = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid) hits++;
        end
        chk("no stale result", hits, 0);
        chk("idle result", result, 16'h0);

        // MUL (or ADD when the multiplier is not built)
`ifdef ALU_EXEC_MUL_EN
        run_op("MUL", 2'b00, 4'b1010, 16'h0123, 16'h0010, 16'h1230, 17);
        run_op("MUL wrap", 2'b00, 4'b1010, 16'h0100, 16'h0101, 16'h0100, 17);
`else
        run_op("opc1010 ADD", 2'b00, 4'b1010, 16'h0123, 16'h0010, 16'h0133, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
